if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline.
- Owns the PC register and drives the read address of the combinational instruction memory (word-indexed by pc[31:2], data valid the same cycle).
- Captures the returned instruction into the IF/ID pipeline register for decode.
- Handles hazard-unit stalls, EX-stage branch/jump redirects with flush, and a halt on EBREAK.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSN, 32'h0000_0013, instruction (addi x0,x0,0) inserted into IF/ID on flush/bubble.
- HALT_ON_EBREAK, 1, when 1 a fetched EBREAK (32'h0010_0073) halts fetch.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall_i  input  1  hazard unit: hold PC and IF/ID contents.
- redirect_i  input  1  EX stage: taken branch/jump, flush IF/ID.
- redirect_pc_i  input  32  redirect target address.
- ins_i  input  32  instruction from instruction memory for address pc_o.
- pc_o  output  32  current PC, to instruction memory.
- if_id_pc_o  output  32  PC of instruction held in IF/ID.
- if_id_pc4_o  output  32  if_id_pc_o + 4 (modulo 2^32), for JAL/JALR link.
- if_id_ins_o  output  32  instruction held in IF/ID.
- if_id_valid_o  output  1  IF/ID holds a real instruction.
- halted_o  output  1  fetch FSM is in HALT.

Behaviour:
- Reset values:
  - pc_o = RESET_PC; if_id_pc_o = 0; if_id_pc4_o = 4; if_id_ins_o = NOP_INSN; if_id_valid_o = 0; halted_o = 0.
  - FSM enters BOOT.
- FSM states:
  - BOOT: exactly one cycle after rst deasserts. PC holds RESET_PC and IF/ID stays invalid. Next state is RUN, unless redirect_i, which loads the target and goes to RUN.
  - RUN: normal fetch (see per-cycle priority).
  - HALT: PC frozen; IF/ID loads NOP_INSN with valid=0 each cycle; halted_o=1. Exits only on rst or redirect_i; redirect loads the target and goes to RUN.
- Per-cycle priority in RUN, highest first:
  1. rst.
  2. redirect_i:
     - PC <= {redirect_pc_i[31:2], 2'b00}.
     - IF/ID <= NOP_INSN, valid=0. The wrong-path instruction is discarded.
     - stall_i is ignored in that cycle.
  3. stall_i: PC and all IF/ID registers hold their values (valid included).
  4. Normal:
     - PC <= PC + 4.
     - if_id_ins <= ins_i; if_id_pc <= PC; if_id_pc4 <= PC + 4; valid <= 1.
- Latency: one cycle. The instruction at address A appears on if_id_ins_o the cycle after pc_o = A, absent stall/redirect.
- EBREAK (only when HALT_ON_EBREAK=1): in normal advance, ins_i == 32'h0010_0073 is latched into IF/ID with valid=1 and the FSM goes to HALT. PC still advances by 4 in that cycle and is then frozen.
- Stall while ins_i is EBREAK: no halt until the instruction is actually latched.
- Arithmetic: PC + 4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0. No bounds check against memory depth; out-of-range addresses are the memory's concern.
- Simultaneous redirect_i and stall_i: redirect wins, as above.
- rst asserted mid-operation (any state, any stall/redirect): all registers take reset values on that edge; FSM goes to BOOT.

Optional Feature:
- Macro: IF_MISALIGN_CHK_EN.
- Defined:
  - Extra output misalign_o (1 bit, reset 0).
  - A redirect with redirect_pc_i[1:0] != 0 does not load the PC: PC holds, IF/ID is flushed (valid=0), misalign_o is set to 1 and the FSM goes to HALT.
  - misalign_o clears only on rst.
- Not defined:
  - No misalign_o port.
  - Redirect low two bits are silently forced to 00.

Test Plan:
- Reset then free run, memory word[i] = i: pc_o = 0,0(BOOT),4,8,12; if_id_ins_o = 0,1,2 on cycles 3,4,5; if_id_valid_o rises on cycle 3; if_id_pc4_o = if_id_pc_o + 4.
- stall_i high for 3 cycles at pc_o = 8: pc_o stays 8 and IF/ID keeps ins 1 / pc 4 / valid 1. Release: next IF/ID = ins 2, pc 8.
- redirect_i with redirect_pc_i = 0x40 while stall_i = 1 at pc_o = 0x10: next cycle pc_o = 0x40, if_id_ins_o = 0x0000_0013, valid = 0. Following cycle IF/ID = word[16], pc 0x40.
- EBREAK at address 0x0C: IF/ID = 0x0010_0073 with valid 1; pc_o freezes at 0x10; halted_o = 1; next cycle valid = 0. A later redirect to 0x0 resumes fetch and halted_o = 0.
- Wrap: redirect to 0xFFFF_FFFC; two cycles later pc_o = 0x0 and if_id_pc4_o = 0x0.
- rst pulsed one cycle mid-run at pc_o = 0x20 with stall_i = 1: pc_o = 0 and valid = 0 after the edge. IF_MISALIGN_CHK_EN build: redirect to 0x42 leaves pc_o unchanged and sets misalign_o = 1 and halted_o = 1.

Source files
------------

// File: rtl/if_stage.sv
// if_stage -- instruction-fetch stage of the 5-stage pipeline.
//
// Owns the PC, addresses a combinational instruction memory (word index
// pc[31:2], data valid in the same cycle) and captures the returned
// instruction into the IF/ID pipeline register. Handles hazard stalls,
// EX-stage redirects with flush, and an optional halt on EBREAK.
//
// Optional build macro: IF_MISALIGN_CHK_EN
//   defined   : adds misalign_o; a redirect to a target that is not word
//               aligned flushes IF/ID, keeps the PC and halts fetch.
//   undefined : redirect targets have their low two bits forced to 00.
//
// Ports:
//   clk            clock, all state updates on rising edge
//   rst            synchronous active-high reset
//   stall_i        hold PC and IF/ID contents
//   redirect_i     taken branch/jump from EX, flushes IF/ID
//   redirect_pc_i  redirect target address
//   ins_i          instruction memory data for address pc_o
//   pc_o           current PC (instruction memory address)
//   if_id_pc_o     PC of the instruction in IF/ID
//   if_id_pc4_o    if_id_pc_o + 4, for link registers
//   if_id_ins_o    instruction in IF/ID
//   if_id_valid_o  IF/ID holds a real instruction
//   misalign_o     (IF_MISALIGN_CHK_EN only) sticky misaligned-redirect flag
//   halted_o       fetch is halted
//
// state  | meaning
// S_BOOT | first cycle after reset, PC parked at RESET_PC, IF/ID invalid
// S_RUN  | normal fetch, one instruction per cycle unless stalled
// S_HALT | PC frozen, IF/ID fed bubbles until a redirect or reset

module if_stage #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN       = 32'h0000_0013,
  parameter bit          HALT_ON_EBREAK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic [31:0] ins_i,
  output logic [31:0] pc_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc4_o,
  output logic [31:0] if_id_ins_o,
  output logic        if_id_valid_o,
`ifdef IF_MISALIGN_CHK_EN
  output logic        misalign_o,
`endif
  output logic        halted_o
);

  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_tgt;
  logic        bad_target;
  logic        ebreak_hit;

  assign pc_plus4     = pc_o + 32'd4;
  // Masking (rather than slicing) keeps every target bit in use in both builds.
  assign redirect_tgt = redirect_pc_i & ~32'h0000_0003;
  assign ebreak_hit   = HALT_ON_EBREAK && (ins_i == EBREAK_INSN);

`ifdef IF_MISALIGN_CHK_EN
  assign bad_target = (redirect_pc_i[1:0] != 2'b00);
`else
  assign bad_target = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_BOOT;
      pc_o          <= RESET_PC;
      if_id_pc_o    <= 32'h0000_0000;
      if_id_pc4_o   <= 32'h0000_0004;
      if_id_ins_o   <= NOP_INSN;
      if_id_valid_o <= 1'b0;
      halted_o      <= 1'b0;
`ifdef IF_MISALIGN_CHK_EN
      misalign_o    <= 1'b0;
`endif
    end else if (redirect_i) begin
      // Redirect beats stall and applies in every state; the wrong-path
      // instruction is dropped.
      if_id_ins_o   <= NOP_INSN;
      if_id_valid_o <= 1'b0;
      if (bad_target) begin
        state    <= S_HALT;
        halted_o <= 1'b1;
`ifdef IF_MISALIGN_CHK_EN
        misalign_o <= 1'b1;
`endif
      end else begin
        pc_o     <= redirect_tgt;
        state    <= S_RUN;
        halted_o <= 1'b0;
      end
    end else begin
      unique case (state)
        S_BOOT: begin
          state <= S_RUN;
        end
        S_RUN: begin
          if (!stall_i) begin
            pc_o          <= pc_plus4;
            if_id_ins_o   <= ins_i;
            if_id_pc_o    <= pc_o;
            if_id_pc4_o   <= pc_plus4;
            if_id_valid_o <= 1'b1;
            // EBREAK is latched as a valid instruction; fetch stops after it.
            if (ebreak_hit) begin
              state    <= S_HALT;
              halted_o <= 1'b1;
            end
          end
        end
        S_HALT: begin
          if_id_ins_o   <= NOP_INSN;
          if_id_valid_o <= 1'b0;
        end
        default: begin
          state    <= S_BOOT;
          halted_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] ins_i;
  logic [31:0] pc_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc4_o;
  logic [31:0] if_id_ins_o;
  logic        if_id_valid_o;
  logic        halted_o;
`ifdef IF_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .ins_i         (ins_i),
    .pc_o          (pc_o),
    .if_id_pc_o    (if_id_pc_o),
    .if_id_pc4_o   (if_id_pc4_o),
    .if_id_ins_o   (if_id_ins_o),
    .if_id_valid_o (if_id_valid_o),
`ifdef IF_MISALIGN_CHK_EN
    .misalign_o    (misalign_o),
`endif
    .halted_o      (halted_o)
  );

  assign ins_i = mem[pc_o[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the fetch stage should hold after each edge.
  logic [31:0] m_pc, m_ipc, m_ins;
  logic        m_valid, m_halt, m_boot, m_mis;
  bit          started = 0;

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      m_pc = 32'h0; m_ipc = 32'h0; m_ins = NOP; m_valid = 0;
      m_halt = 0; m_boot = 1; m_mis = 0;
    end else if (redirect_i) begin
      m_ins = NOP; m_valid = 0; m_boot = 0;
`ifdef IF_MISALIGN_CHK_EN
      if (redirect_pc_i[1:0] != 2'b00) begin
        m_halt = 1; m_mis = 1;
      end else begin
        m_pc = redirect_pc_i; m_halt = 0;
      end
`else
      m_pc = {redirect_pc_i[31:2], 2'b00}; m_halt = 0;
`endif
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_halt) begin
      m_ins = NOP; m_valid = 0;
    end else if (!stall_i) begin
      m_ins   = mem[m_pc[9:2]];
      m_ipc   = m_pc;
      m_valid = 1;
      m_pc    = m_pc + 32'd4;
      if (m_ins == EBREAK) m_halt = 1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("pc", pc_o, m_pc);
      check("ins", if_id_ins_o, m_ins);
      check("valid", {31'b0, if_id_valid_o}, {31'b0, m_valid});
      check("halted", {31'b0, halted_o}, {31'b0, m_halt});
`ifdef IF_MISALIGN_CHK_EN
      check("misalign", {31'b0, misalign_o}, {31'b0, m_mis});
`endif
      if (m_valid) begin
        check("if_id_pc", if_id_pc_o, m_ipc);
        check("if_id_pc4", if_id_pc4_o, m_ipc + 32'd4);
      end
    end
  end

  // Advance one edge with the given inputs and come back at the falling edge.
  task automatic step(input logic s, input logic r, input logic [31:0] tgt);
    stall_i = s; redirect_i = r; redirect_pc_i = tgt;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i;
    rst = 1; stall_i = 0; redirect_i = 0; redirect_pc_i = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pc", pc_o, 32'h0);
    check("rst_if_id_pc", if_id_pc_o, 32'h0);
    check("rst_pc4", if_id_pc4_o, 32'h4);
    check("rst_ins", if_id_ins_o, NOP);
    check("rst_valid", {31'b0, if_id_valid_o}, 32'h0);
    check("rst_halted", {31'b0, halted_o}, 32'h0);
    rst = 0;

    // BOOT, then free run
    step(0, 0, 0);
    check("boot_pc", pc_o, 32'h0);
    check("boot_valid", {31'b0, if_id_valid_o}, 32'h0);
    step(0, 0, 0);
    check("run1_pc", pc_o, 32'h4);
    check("run1_ins", if_id_ins_o, 32'h0);
    check("run1_valid", {31'b0, if_id_valid_o}, 32'h1);
    check("run1_pc4", if_id_pc4_o, 32'h4);
    step(0, 0, 0);
    check("run2_pc", pc_o, 32'h8);
    check("run2_ins", if_id_ins_o, 32'h1);

    // stall three cycles at pc 8
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      check("stall_pc", pc_o, 32'h8);
      check("stall_ins", if_id_ins_o, 32'h1);
      check("stall_if_id_pc", if_id_pc_o, 32'h4);
    end
    step(0, 0, 0);
    check("release_ins", if_id_ins_o, 32'h2);
    check("release_if_id_pc", if_id_pc_o, 32'h8);
    step(0, 0, 0);
    check("pre_redir_pc", pc_o, 32'h10);

    // redirect with stall at pc 0x10
    step(1, 1, 32'h40);
    check("redir_pc", pc_o, 32'h40);
    check("redir_ins", if_id_ins_o, NOP);
    check("redir_valid", {31'b0, if_id_valid_o}, 32'h0);
    step(0, 0, 0);
    check("redir_next_ins", if_id_ins_o, 32'd16);
    check("redir_next_pc", if_id_pc_o, 32'h40);

    // EBREAK at 0x0C
    mem[3] = EBREAK;
    step(0, 1, 32'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    check("ebreak_ins", if_id_ins_o, EBREAK);
    check("ebreak_valid", {31'b0, if_id_valid_o}, 32'h1);
    check("ebreak_pc", pc_o, 32'h10);
    check("ebreak_halted", {31'b0, halted_o}, 32'h1);
    step(1, 0, 0);
    check("halt_valid", {31'b0, if_id_valid_o}, 32'h0);
    check("halt_pc", pc_o, 32'h10);
    step(0, 1, 32'h0);
    check("resume_halted", {31'b0, halted_o}, 32'h0);
    check("resume_pc", pc_o, 32'h0);
    mem[3] = 32'h3;

    // PC wrap
    step(0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0);
    check("wrap_pc", pc_o, 32'h0);
    check("wrap_pc4", if_id_pc4_o, 32'h0);
    check("wrap_if_id_pc", if_id_pc_o, 32'hFFFF_FFFC);

    // reset mid-run with stall
    step(0, 1, 32'h20);
    rst = 1;
    step(1, 0, 0);
    rst = 0;
    check("midrst_pc", pc_o, 32'h0);
    check("midrst_valid", {31'b0, if_id_valid_o}, 32'h0);
    step(0, 0, 0);
    step(0, 0, 0);

`ifdef IF_MISALIGN_CHK_EN
    step(0, 0, 0);
    step(0, 1, 32'h42);
    check("mis_pc", pc_o, 32'h8);
    check("mis_flag", {31'b0, misalign_o}, 32'h1);
    check("mis_halted", {31'b0, halted_o}, 32'h1);
    rst = 1;
    step(0, 0, 0);
    rst = 0;
`endif

    // randomized traffic against the model
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? EBREAK : $urandom;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           ($urandom_range(0, 3) == 0) ? $urandom : {22'b0, $urandom_range(0, 1023)});
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
